unary_stream_decoder: RTL
=========================

// Module: unary_stream_decoder
// PURPOSE
//   Converts a unary/stochastic bitstream (e.g. the output of the unary
//   multiplier datapath) back to binary by counting the 1s over a fixed window
//   of 2^BITWIDTH sampled bits.
//   Sits at the output end of a unary compute chain; its result has the same
//   BITWIDTH+1 width as the multiplier oData. Results leave on a valid/ready
//   handshake.
// PARAMETERS
//   BITWIDTH  8  window = 2^BITWIDTH sampled bits; result width BITWIDTH+1
// PORTS
//   iClk    in   1           clock, all state on rising edge
//   iRst    in   1           asynchronous, active-high reset
//   iEn     in   1           sample enable; iBit counted only when iEn=1
//   iClr    in   1           synchronous abort/clear
//   iStart  in   1           begin a new decode window
//   iBit    in   1           unary stream bit
//   oData   out  BITWIDTH+1  count of 1s in last completed window (0..2^BITWIDTH)
//   oValid  out  1           oData holds a result not yet accepted
//   iReady  in   1           downstream accepts oData when oValid&&iReady
//   oBusy   out  1           window in progress (state ACCUM)
// BEHAVIOUR
//   - Reset (iRst=1, any time, asynchronous): state IDLE; oData=0, oValid=0,
//     oBusy=0; window counter and accumulator = 0.
//   - FSM states IDLE, ACCUM, DONE.
//     IDLE  -> ACCUM on iStart=1. Window counter and accumulator clear on entry.
//     ACCUM: each cycle with iEn=1: acc += iBit, win += 1. iEn=0 pauses; no
//            state changes. iStart is ignored.
//            The sample that makes win reach 2^BITWIDTH ends the window.
//            On the next edge: state DONE, oData <= final acc, oValid=1.
//     DONE: oData and oValid are held stable until handshake (oValid&&iReady).
//           After handshake: -> IDLE, or -> ACCUM if iStart=1 in the same cycle
//           (back-to-back, no bubble).
//           iStart without iReady is ignored.
//   - The last sample's iBit is included in oData. oValid rises on the edge that
//     takes the last enabled sample. Latency from iStart is therefore
//     2^BITWIDTH enabled cycles + 1 edge.
//   - Arithmetic: win is BITWIDTH+1 bits. acc is BITWIDTH+1 bits and cannot
//     overflow (max 2^BITWIDTH). No saturation logic is needed; an
//     all-ones window gives oData = 1<<BITWIDTH.
//   - iClr=1 (synchronous, priority over all but iRst): -> IDLE. Clears win,
//     acc, oData and oValid; a pending result is discarded.
//     iClr together with iStart: iClr wins and the state stays IDLE.
//   - oBusy = (state==ACCUM), registered with the state.
//   - iBit is don't-care outside ACCUM or when iEn=0.
// TESTING (BITWIDTH=4, window 16)
//   1. iStart pulse, iEn=1, iBit=1 for 16 cycles
//      -> oValid=1 on the 16th sample edge, oData=5'd16.
//   2. iBit=0 for a whole window -> oData=0, oValid=1. Repeat with iBit
//      alternating 1,0 -> oData=8.
//   3. iBit=1 with iEn toggling 1,0 -> oValid only after 16 enabled samples
//      (32 cycles); oData=16; oBusy high throughout.
//   4. Result pending, iReady=0 for 10 cycles -> oData/oValid stable. Then
//      iReady=1 with iStart=1 -> oValid drops; next cycle oBusy=1 and a new
//      window starts with acc=0.
//   5. iClr during ACCUM after 5 ones -> next cycle IDLE, oBusy=0, oValid=0.
//      A fresh all-ones window then yields 16, not 21.
//   6. iRst asserted mid-window and mid-DONE, between clock edges -> all
//      outputs 0 immediately. iStart is ignored until iRst is released.

Source files
------------

// File: rtl/unary_stream_decoder.sv
// unary_stream_decoder
// Counts the 1s in a window of 2^BITWIDTH enabled samples of a unary bitstream
// and presents the count on a valid/ready output. The FSM state is also driven
// on oState so that checkers can observe it.
module unary_stream_decoder #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iStart,
    input  logic                iBit,
    output logic [BITWIDTH:0]   oData,
    output logic                oValid,
    input  logic                iReady,
    output logic                oBusy,
    output logic [1:0]          oState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Value of win just before the sample that completes the window.
    localparam logic [BITWIDTH:0] WIN_LAST = {1'b0, {BITWIDTH{1'b1}}};

    state_t            state;
    logic [BITWIDTH:0] win;
    logic [BITWIDTH:0] acc;
    logic [BITWIDTH:0] accNext;

    // Handshake: oData is transferred on any rising edge where oValid && iReady.
    // While oValid is high, oData and oValid do not change until that transfer
    // (or until iClr/iRst discard the result). oValid never depends on iReady.

    // Accumulator plus the current sample, zero-extended to the result width.
    always_comb begin
        accNext = acc + {{BITWIDTH{1'b0}}, iBit};
    end

    // Window FSM with registered outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state  <= IDLE;
            win    <= '0;
            acc    <= '0;
            oData  <= '0;
            oValid <= 1'b0;
            oBusy  <= 1'b0;
        end else if (iClr) begin
            // Abort: any window in progress and any pending result are dropped.
            state  <= IDLE;
            win    <= '0;
            acc    <= '0;
            oData  <= '0;
            oValid <= 1'b0;
            oBusy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state <= ACCUM;
                        win   <= '0;
                        acc   <= '0;
                        oBusy <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (iEn) begin
                        win <= win + 1'b1;
                        acc <= accNext;
                        if (win == WIN_LAST) begin
                            // This sample completes the window; it is included.
                            state  <= DONE;
                            oData  <= accNext;
                            oValid <= 1'b1;
                            oBusy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (oValid && iReady) begin
                        oValid <= 1'b0;
                        if (iStart) begin
                            // Back-to-back window without an idle cycle.
                            state <= ACCUM;
                            win   <= '0;
                            acc   <= '0;
                            oBusy <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    oValid <= 1'b0;
                    oBusy  <= 1'b0;
                end
            endcase
        end
    end

    // Debug view of the FSM state.
    always_comb begin
        oState = state;
    end

endmodule
